// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I encodings: ALU control, load/store funct3 codes,
//               LSU state enumeration and LSU exception cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int c_XLEN = 32;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLL  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SLT  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ   = 3'd1,
        LSU_WAIT  = 3'd2,
        LSU_DONE  = 3'd3,
        LSU_FAULT = 3'd4
    } lsu_state_t;

    localparam logic [1:0] EXC_LD_MISALIGN = 2'd0;
    localparam logic [1:0] EXC_ST_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu_align
// Description : Combinational byte-lane steering for stores, load data
//               extraction/extension and access legality checking.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_lane,
    output logic            fault,
    output logic [1:0]      cause,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    logic            w_illegal;
    logic            w_misaligned;
    logic [XLEN-1:0] w_shifted;

    always_comb begin
        be         = 4'hF;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'hF;
                wdata_lane = wdata;
            end
        endcase
    end

    // Illegal encodings take precedence over alignment so cause 2 wins.
    always_comb begin
        w_illegal = (mem_read && mem_write)
                 || (mem_read  && ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7)))
                 || (mem_write && (funct3 >= 3'd3));
        case (funct3[1:0])
            2'b01:   w_misaligned = addr_lo[0];
            2'b10:   w_misaligned = (addr_lo != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        fault = w_illegal || w_misaligned;
        if (w_illegal) begin
            cause = EXC_ILLEGAL;
        end else if (mem_read) begin
            cause = EXC_LD_MISALIGN;
        end else begin
            cause = EXC_ST_MISALIGN;
        end
    end

    always_comb begin
        w_shifted = rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_LB:   ld_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   ld_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: ld_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu
// Description : RV32I load/store unit: single outstanding op over a
//               req/gnt + rvalid data bus, with fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RD_W-1:0] rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            exc_valid,
    output logic [1:0]      exc_cause,
    output logic [XLEN-1:0] exc_addr
);

    lsu_state_t      r_state;
    lsu_state_t      w_next;

    logic            w_accept;
    logic            w_fault;
    logic [1:0]      w_cause;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_lane;
    logic [XLEN-1:0] w_ld_data;

    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [RD_W-1:0] r_rd;
    logic [XLEN-1:0] r_addr;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_wdata;
    logic [RD_W-1:0] r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic [1:0]      r_exc_cause;
    logic [XLEN-1:0] r_exc_addr;

    assign w_accept = req_valid && (r_state == LSU_IDLE) && (mem_read || mem_write);

    riscv_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (w_be),
        .wdata_lane (w_wdata_lane),
        .fault      (w_fault),
        .cause      (w_cause),
        .ld_funct3  (r_funct3),
        .ld_off     (r_off),
        .rdata      (dmem_rdata),
        .ld_data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE:  if (w_accept) w_next = w_fault ? LSU_FAULT : LSU_REQ;
            LSU_REQ:   if (dmem_gnt) w_next = r_we ? LSU_DONE : LSU_WAIT;
            LSU_WAIT:  if (dmem_rvalid) w_next = LSU_DONE;
            LSU_DONE:  w_next = LSU_IDLE;
            LSU_FAULT: w_next = LSU_IDLE;
            default:   w_next = LSU_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == LSU_IDLE);
        dmem_req  = (r_state == LSU_REQ);
        dmem_we   = (r_state == LSU_REQ) && r_we;
        done      = (r_state == LSU_DONE) || (r_state == LSU_FAULT);
        wb_valid  = (r_state == LSU_DONE) && !r_we;
        exc_valid = (r_state == LSU_FAULT);
    end

    // Request fields are frozen at accept so the bus stays stable until gnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_rd        <= '0;
            r_addr      <= '0;
            r_be        <= 4'd0;
            r_wdata     <= '0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_exc_cause <= 2'd0;
            r_exc_addr  <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= mem_write;
                r_funct3 <= funct3;
                r_off    <= addr[1:0];
                r_rd     <= rd;
                r_addr   <= {addr[XLEN-1:2], 2'b00};
                r_be     <= w_be;
                r_wdata  <= w_wdata_lane;
                if (w_fault) begin
                    r_exc_cause <= w_cause;
                    r_exc_addr  <= addr;
                end
            end
            if ((r_state == LSU_WAIT) && dmem_rvalid) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_ld_data;
            end
        end
    end

    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign exc_cause  = r_exc_cause;
    assign exc_addr   = r_exc_addr;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_lsu
// Description : Directed scoreboard bench for riscv_lsu with a small
//               req/gnt/rvalid memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, done, exc_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_addr;
    logic [1:0]  exc_cause;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          wb;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        bit          exc;
        logic [1:0]  cause;
        logic [31:0] eaddr;
        int          lat;
        bit          req;
        logic [31:0] d_addr;
        logic [3:0]  d_be;
        logic [31:0] d_wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  last_rd   = 5'd0;
    logic [31:0] last_wb   = 32'h0;
    logic [1:0]  last_c    = 2'd0;
    logic [31:0] last_eadr = 32'h0;

    riscv_lsu #(.XLEN(32), .RD_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rd         (rd),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .done       (done),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_addr   (exc_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, act as the memory, and score the completion.
    task automatic do_op(input string nm, input bit rdo, input bit wro, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdi,
                         input int gdly, input logic [31:0] rdat, input exp_t e);
        exp_t got;
        int   waited = 0;
        bit   rv_pend = 0;
        bit   saw_req = 0;
        bit   fin = 0;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; mem_read = rdo; mem_write = wro;
        funct3 = f3; addr = a; wdata = wd; rd = rdi;
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        for (int k = 1; k <= 40 && !fin; k++) begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (rv_pend) begin
                dmem_rvalid = 1'b1; dmem_rdata = rdat; rv_pend = 0;
            end
            if (k == 1) chk({nm, ".busy"}, {31'd0, req_ready}, 32'd0);
            if (done) begin
                got = exp_q.pop_front();
                if (got.wb) begin last_rd = got.wb_rd; last_wb = got.wb_data; end
                if (got.exc) begin last_c = got.cause; last_eadr = got.eaddr; end
                chk({nm, ".lat"},      k, got.lat);
                chk({nm, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, got.wb});
                chk({nm, ".wb_rd"},    {27'd0, wb_rd}, {27'd0, last_rd});
                chk({nm, ".wb_data"},  wb_data, last_wb);
                chk({nm, ".exc"},      {31'd0, exc_valid}, {31'd0, got.exc});
                chk({nm, ".cause"},    {30'd0, exc_cause}, {30'd0, last_c});
                chk({nm, ".exc_addr"}, exc_addr, last_eadr);
                chk({nm, ".saw_req"},  {31'd0, saw_req}, {31'd0, got.req});
                fin = 1;
            end else if (dmem_req) begin
                if (!saw_req) begin
                    chk({nm, ".d_addr"}, dmem_addr, got_addr(e));
                    chk({nm, ".d_we"},   {31'd0, dmem_we}, {31'd0, wro});
                    if (wro) begin
                        chk({nm, ".d_be"},    {28'd0, dmem_be}, {28'd0, e.d_be});
                        chk({nm, ".d_wdata"}, dmem_wdata, e.d_wdata);
                    end
                end
                saw_req = 1;
                if (waited == gdly) begin
                    dmem_gnt = 1'b1;
                    if (rdo) rv_pend = 1;
                end else begin
                    waited++;
                end
            end
        end
        if (!fin) begin
            chk({nm, ".timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk({nm, ".pulse"}, {30'd0, done, wb_valid}, 32'd0);
    endtask

    function automatic logic [31:0] got_addr(input exp_t e);
        return e.d_addr;
    endfunction

    initial begin
        reset = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'h0; wdata = 32'h0; rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.outs", {26'd0, dmem_req, dmem_we, done, wb_valid, exc_valid, 1'b0}, 32'd0);
        chk("rst.bus", dmem_addr | dmem_wdata | {28'd0, dmem_be}, 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);

        //      name   rd wr f3    addr          wdata         rd    dly rdata
        do_op("sw",   0, 1, 3'd2, 32'h0000_0100, 32'hDEADBEEF, 5'd1, 0, 32'h0,
              '{0, 5'd0, 32'h0, 0, 2'd0, 32'h0, 2, 1, 32'h100, 4'hF, 32'hDEADBEEF});
        do_op("sb",   0, 1, 3'd0, 32'h0000_0103, 32'h0000005A, 5'd1, 0, 32'h0,
              '{0, 5'd0, 32'h0, 0, 2'd0, 32'h0, 2, 1, 32'h100, 4'b1000, 32'h5A5A5A5A});
        do_op("sh",   0, 1, 3'd1, 32'h0000_0102, 32'h1234ABCD, 5'd1, 2, 32'h0,
              '{0, 5'd0, 32'h0, 0, 2'd0, 32'h0, 4, 1, 32'h100, 4'b1100, 32'hABCDABCD});
        do_op("lb",   1, 0, 3'd0, 32'h0000_0201, 32'h0, 5'd3, 0, 32'h00008000,
              '{1, 5'd3, 32'hFFFFFF80, 0, 2'd0, 32'h0, 3, 1, 32'h200, 4'h0, 32'h0});
        do_op("lbu",  1, 0, 3'd4, 32'h0000_0201, 32'h0, 5'd4, 0, 32'h00008000,
              '{1, 5'd4, 32'h00000080, 0, 2'd0, 32'h0, 3, 1, 32'h200, 4'h0, 32'h0});
        do_op("lhu",  1, 0, 3'd5, 32'h0000_0302, 32'h0, 5'd7, 0, 32'hBEEF1234,
              '{1, 5'd7, 32'h0000BEEF, 0, 2'd0, 32'h0, 3, 1, 32'h300, 4'h0, 32'h0});
        do_op("lh",   1, 0, 3'd1, 32'h0000_0300, 32'h0, 5'd9, 0, 32'h12348001,
              '{1, 5'd9, 32'hFFFF8001, 0, 2'd0, 32'h0, 3, 1, 32'h300, 4'h0, 32'h0});
        do_op("lw",   1, 0, 3'd2, 32'h0000_0400, 32'h0, 5'd31, 1, 32'hCAFEF00D,
              '{1, 5'd31, 32'hCAFEF00D, 0, 2'd0, 32'h0, 4, 1, 32'h400, 4'h0, 32'h0});
        do_op("lw_mis", 1, 0, 3'd2, 32'h0000_0402, 32'h0, 5'd5, 0, 32'h0,
              '{0, 5'd0, 32'h0, 1, 2'd0, 32'h402, 1, 0, 32'h0, 4'h0, 32'h0});
        do_op("sh_mis", 0, 1, 3'd1, 32'h0000_0101, 32'h0, 5'd5, 0, 32'h0,
              '{0, 5'd0, 32'h0, 1, 2'd1, 32'h101, 1, 0, 32'h0, 4'h0, 32'h0});
        do_op("ld_f3", 1, 0, 3'd3, 32'h0000_0800, 32'h0, 5'd5, 0, 32'h0,
              '{0, 5'd0, 32'h0, 1, 2'd2, 32'h800, 1, 0, 32'h0, 4'h0, 32'h0});
        do_op("st_f3", 0, 1, 3'd4, 32'h0000_0804, 32'h0, 5'd5, 0, 32'h0,
              '{0, 5'd0, 32'h0, 1, 2'd2, 32'h804, 1, 0, 32'h0, 4'h0, 32'h0});
        do_op("rdwr", 1, 1, 3'd2, 32'h0000_0808, 32'h0, 5'd5, 0, 32'h0,
              '{0, 5'd0, 32'h0, 1, 2'd2, 32'h808, 1, 0, 32'h0, 4'h0, 32'h0});

        // Op with neither read nor write must be ignored.
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h900;
        @(negedge clk);
        req_valid = 1'b0;
        chk("nop.ready", {31'd0, req_ready}, 32'd1);
        chk("nop.outs", {29'd0, dmem_req, done, exc_valid}, 32'd0);

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h500; rd = 5'd2;
        @(posedge clk);
        #1 req_valid = 1'b0; mem_read = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstw.req_hold", {31'd0, dmem_req}, 32'd1);
        end
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("rstw.in_wait", {31'd0, dmem_req}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstw.ready", {31'd0, req_ready}, 32'd1);
        chk("rstw.no_req", {31'd0, dmem_req}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstw.ignored", {30'd0, done, wb_valid}, 32'd0);
        end
        chk("rstw.wb_data", wb_data, 32'd0);
        chk("rstw.ready2", {31'd0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
